// File: rtl/dmem_ram_bridge.sv
// -----------------------------------------------------------------------------
// dmem_ram_bridge
//
// Core-side requester for the external RAM controller. It turns the core's
// level-style data-memory bus into the controller's request/ready/valid
// handshake and stalls the core until each access completes. A watchdog
// completes a hung access with a sticky error flag. A timed-out read returns
// ERR_DATA.
//
// Optional feature (compile-time macro):
//   DMEM_POSTED_WRITE_EN - posted writes. A write seen in IDLE does not stall
//                          the core. The block issues it in the background and
//                          returns straight to IDLE once it is accepted.
//
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   DATA_ENABLE       core requests an access
//   DATA_WRITE        1 = write, 0 = read (qualified by DATA_ENABLE)
//   DATA_ADDR         access address
//   DATA_BUS          write data
//   DATA_RDATA        read data, valid in the cycle DATA_STALL drops for a read
//   DATA_STALL        core must hold its request while high
//   ERR               sticky watchdog-timeout flag, cleared only by RST
//   addr_out          address to ram (holding register)
//   write_data_out    write data to ram (holding register)
//   read_req          read request to ram
//   write_req         write request to ram
//   read_ready        ram can accept a read
//   write_ready       ram can accept a write
//   read_data_valid   read_data_in carries the response
//   read_data_in      read response data
// -----------------------------------------------------------------------------
module dmem_ram_bridge #(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              DATA_ENABLE,
   input  logic              DATA_WRITE,
   input  logic [ADDR_W-1:0] DATA_ADDR,
   input  logic [DATA_W-1:0] DATA_BUS,
   output logic [DATA_W-1:0] DATA_RDATA,
   output logic              DATA_STALL,
   output logic              ERR,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] write_data_out,
   output logic              read_req,
   output logic              write_req,
   input  logic              read_ready,
   input  logic              write_ready,
   input  logic              read_data_valid,
   input  logic [DATA_W-1:0] read_data_in
);

`ifdef DMEM_POSTED_WRITE_EN
   localparam logic POSTED = 1'b1;
`else
   localparam logic POSTED = 1'b0;
`endif

   localparam int               CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      RD_WAIT,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wd_cnt;
   logic             wd_fire;
   logic [CNT_W-1:0] wd_next;

   assign wd_fire = (wd_cnt == WD_LAST);
   // The counter saturates at its terminal value. A read accepted on the
   // final cycle therefore times out on the next cycle instead of wrapping
   // around and getting a fresh budget.
   assign wd_next = wd_fire ? wd_cnt : wd_cnt + CNT_W'(1);

   // NOTE: the stall is combinational so the core sees it in the same cycle
   // it raises DATA_ENABLE; a registered stall would let one access slip by.
   assign DATA_STALL = DATA_ENABLE && (state != DONE)
                       && !(POSTED && (state == IDLE) && DATA_WRITE);

   // NOTE: every register here sits in one clocked block with non-blocking
   // assignments, so the requests and holding registers are glitch-free
   // flops and the asynchronous reset drops the requests at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state          <= IDLE;
         wd_cnt         <= '0;
         read_req       <= 1'b0;
         write_req      <= 1'b0;
         ERR            <= 1'b0;
         DATA_RDATA     <= '0;
         addr_out       <= '0;
         write_data_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (DATA_ENABLE) begin
                  addr_out       <= DATA_ADDR;
                  write_data_out <= DATA_BUS;
                  wd_cnt         <= '0;
                  if (DATA_WRITE) begin
                     write_req <= 1'b1;
                     state     <= WR_REQ;
                  end else begin
                     read_req <= 1'b1;
                     state    <= RD_REQ;
                  end
               end
            end

            WR_REQ: begin
               wd_cnt <= wd_next;
               // An accepted handshake takes priority over a watchdog expiry
               // on the same edge.
               if (write_ready) begin
                  write_req <= 1'b0;
                  state     <= POSTED ? IDLE : DONE;
               end else if (wd_fire) begin
                  write_req <= 1'b0;
                  ERR       <= 1'b1;
                  state     <= POSTED ? IDLE : DONE;
               end
            end

            RD_REQ: begin
               wd_cnt <= wd_next;
               if (read_ready) begin
                  read_req <= 1'b0;
                  // The response may arrive on the same edge as the acceptance.
                  if (read_data_valid) begin
                     DATA_RDATA <= read_data_in;
                     state      <= DONE;
                  end else begin
                     state <= RD_WAIT;
                  end
               end else if (wd_fire) begin
                  read_req   <= 1'b0;
                  DATA_RDATA <= ERR_DATA;
                  ERR        <= 1'b1;
                  state      <= DONE;
               end
            end

            RD_WAIT: begin
               wd_cnt <= wd_next;
               if (read_data_valid) begin
                  DATA_RDATA <= read_data_in;
                  state      <= DONE;
               end else if (wd_fire) begin
                  DATA_RDATA <= ERR_DATA;
                  ERR        <= 1'b1;
                  state      <= DONE;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state     <= IDLE;
               read_req  <= 1'b0;
               write_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ram_bridge.sv
module tb_dmem_ram_bridge;

   localparam int TIMEOUT = 12;

`ifdef DMEM_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        DATA_ENABLE, DATA_WRITE;
   logic [31:0] DATA_ADDR, DATA_BUS, DATA_RDATA;
   logic        DATA_STALL, ERR;
   logic [31:0] addr_out, write_data_out;
   logic        read_req, write_req;
   logic        read_ready, write_ready, read_data_valid;
   logic [31:0] read_data_in;

   always #5 CLK = ~CLK;

   dmem_ram_bridge #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TIMEOUT), .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .CLK(CLK), .RST(RST),
      .DATA_ENABLE(DATA_ENABLE), .DATA_WRITE(DATA_WRITE), .DATA_ADDR(DATA_ADDR),
      .DATA_BUS(DATA_BUS), .DATA_RDATA(DATA_RDATA), .DATA_STALL(DATA_STALL), .ERR(ERR),
      .addr_out(addr_out), .write_data_out(write_data_out),
      .read_req(read_req), .write_req(write_req),
      .read_ready(read_ready), .write_ready(write_ready),
      .read_data_valid(read_data_valid), .read_data_in(read_data_in)
   );

   typedef struct {
      logic [31:0] rdata;
      int          stalls;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   // RAM responder configuration
   int          cfg_rd_wait = 0;   // read_req cycles with read_ready low
   int          cfg_rd_lat  = 1;   // cycles from acceptance to valid (0 = same edge)
   int          cfg_wr_wait = 0;   // write_req cycles with write_ready low
   bit          cfg_rd_hang = 1'b0;
   bit          cfg_wr_hang = 1'b0;
   bit          cfg_force_valid = 1'b0;
   logic [31:0] cfg_rd_data = 32'h0;

   // Bus monitor
   int          rd_req_cycles = 0;
   int          wr_req_cycles = 0;
   int          overlap       = 0;
   logic [31:0] mon_w_addr = '0, mon_w_data = '0, mon_r_addr = '0;

   logic [31:0] exp_rd = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Responder and monitor: evaluated 1ns after each rising edge.
   initial begin
      int rd_cnt, wr_cnt, lat_cnt;
      bit hs, valid_now;
      rd_cnt = 0; wr_cnt = 0; lat_cnt = -1; hs = 1'b0;
      read_ready = 1'b0; write_ready = 1'b0; read_data_valid = 1'b0; read_data_in = '0;
      forever begin
         @(posedge CLK); #1;
         if (read_req) rd_req_cycles++;
         if (read_req) mon_r_addr = addr_out;
         if (write_req) begin
            wr_req_cycles++;
            mon_w_addr = addr_out;
            mon_w_data = write_data_out;
         end
         if (read_req && write_req) overlap++;
         if (RST) begin
            rd_cnt = 0; wr_cnt = 0; lat_cnt = -1; hs = 1'b0;
            read_ready = 1'b0; write_ready = 1'b0;
            read_data_valid = cfg_force_valid;
            read_data_in = cfg_force_valid ? cfg_rd_data : '0;
            continue;
         end
         valid_now = 1'b0;
         if (lat_cnt >= 0) lat_cnt++;
         if (hs) lat_cnt = 1;
         hs = 1'b0;
         if (read_req) begin
            rd_cnt++;
            read_ready = !cfg_rd_hang && (rd_cnt > cfg_rd_wait);
         end else begin
            rd_cnt = 0;
            read_ready = 1'b0;
         end
         if (read_req && read_ready) begin
            if (cfg_rd_lat == 0) valid_now = 1'b1;
            else hs = 1'b1;
         end
         if (lat_cnt > 0 && lat_cnt == cfg_rd_lat) begin
            valid_now = 1'b1;
            lat_cnt = -1;
         end
         read_data_valid = valid_now || cfg_force_valid;
         read_data_in    = (valid_now || cfg_force_valid) ? cfg_rd_data : '0;
         if (write_req) begin
            wr_cnt++;
            write_ready = !cfg_wr_hang && (wr_cnt > cfg_wr_wait);
         end else begin
            wr_cnt = 0;
            write_ready = 1'b0;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // One core access, started 1ns after an edge. Holds DATA_ENABLE until the
   // stall drops, counts stalled cycles and compares against the scoreboard.
   task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata_exp, input int stalls_exp,
                         input logic err_exp, input string tag);
      exp_t e, got;
      int   stalls;
      bit   done;
      e.rdata = rdata_exp; e.stalls = stalls_exp; e.err = err_exp;
      sb_q.push_back(e);
      DATA_WRITE = wr; DATA_ADDR = addr; DATA_BUS = wdata; DATA_ENABLE = 1'b1;
      stalls = 0; done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!DATA_STALL) begin
            done = 1'b1;
            break;
         end
         stalls++;
         @(posedge CLK); #1;
      end
      got = sb_q.pop_front();
      check({tag, "_completes"}, 32'(done), 32'd1);
      check({tag, "_stalls"}, 32'(stalls), 32'(got.stalls));
      check({tag, "_rdata"}, DATA_RDATA, got.rdata);
      check({tag, "_err"}, 32'(ERR), 32'(got.err));
      @(posedge CLK); #1;
      DATA_ENABLE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int r0, w0;
      RST = 1'b1; DATA_ENABLE = 1'b0; DATA_WRITE = 1'b0; DATA_ADDR = '0; DATA_BUS = '0;
      repeat (2) @(posedge CLK);
      #1;
      // Reset state
      check("rst_read_req", 32'(read_req), 32'd0);
      check("rst_write_req", 32'(write_req), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_rdata", DATA_RDATA, 32'h0);
      check("rst_addr_out", addr_out, 32'h0);
      check("rst_wdata_out", write_data_out, 32'h0);
      DATA_ENABLE = 1'b1; #1;
      check("rst_stall_en1", 32'(DATA_STALL), 32'd1);
      DATA_ENABLE = 1'b0; #1;
      check("rst_stall_en0", 32'(DATA_STALL), 32'd0);
      idle(1);
      RST = 1'b0;
      idle(1);

      // Minimum-latency write
      r0 = rd_req_cycles; w0 = wr_req_cycles;
      access(1'b1, 32'h100, 32'hA5A5A5A5, exp_rd, POSTED ? 0 : 2, 1'b0, "wr_min");
      idle(2);
      check("wr_min_req_cycles", 32'(wr_req_cycles - w0), 32'd1);
      check("wr_min_rd_cycles", 32'(rd_req_cycles - r0), 32'd0);
      check("wr_min_addr", mon_w_addr, 32'h100);
      check("wr_min_data", mon_w_data, 32'hA5A5A5A5);

      // Minimum-latency read: valid one cycle after acceptance
      cfg_rd_wait = 0; cfg_rd_lat = 1; cfg_rd_data = 32'h11223344; exp_rd = 32'h11223344;
      r0 = rd_req_cycles;
      access(1'b0, 32'h104, 32'h0, exp_rd, 3, 1'b0, "rd_min");
      idle(2);
      check("rd_min_req_cycles", 32'(rd_req_cycles - r0), 32'd1);
      check("rd_min_addr", mon_r_addr, 32'h104);

      // Read with ready low 5 cycles, valid 2 cycles after acceptance
      cfg_rd_wait = 5; cfg_rd_lat = 2; cfg_rd_data = 32'h12345678; exp_rd = 32'h12345678;
      r0 = rd_req_cycles;
      access(1'b0, 32'h100, 32'h0, exp_rd, 9, 1'b0, "rd_slow");
      idle(2);
      check("rd_slow_req_cycles", 32'(rd_req_cycles - r0), 32'd6);
      check("rd_slow_addr", mon_r_addr, 32'h100);

      // Response on the same edge as acceptance
      cfg_rd_wait = 0; cfg_rd_lat = 0; cfg_rd_data = 32'hCAFEF00D; exp_rd = 32'hCAFEF00D;
      access(1'b0, 32'h108, 32'h0, exp_rd, 2, 1'b0, "rd_same_edge");
      idle(2);

      // Watchdog on a read that is never accepted
      cfg_rd_hang = 1'b1; cfg_rd_lat = 1; exp_rd = 32'hDEADBEEF;
      r0 = rd_req_cycles;
      access(1'b0, 32'h300, 32'h0, exp_rd, TIMEOUT + 1, 1'b1, "rd_timeout");
      idle(2);
      check("rd_timeout_req_cycles", 32'(rd_req_cycles - r0), 32'(TIMEOUT));
      cfg_rd_hang = 1'b0;

      // ERR stays set across later successful accesses
      access(1'b1, 32'h304, 32'h01020304, exp_rd, POSTED ? 0 : 2, 1'b1, "wr_after_err");
      idle(2);
      cfg_rd_data = 32'h55AA55AA; exp_rd = 32'h55AA55AA;
      access(1'b0, 32'h308, 32'h0, exp_rd, 3, 1'b1, "rd_after_err");
      idle(2);

      // Reset while the read waits for its response
      cfg_rd_wait = 0; cfg_rd_lat = 50; cfg_rd_data = 32'h77777777;
      DATA_WRITE = 1'b0; DATA_ADDR = 32'h400; DATA_ENABLE = 1'b1;
      idle(1);
      check("rstmid_rd_req_issued", 32'(read_req), 32'd1);
      idle(1);
      check("rstmid_stall_in_wait", 32'(DATA_STALL), 32'd1);
      #2 RST = 1'b1;
      #1;
      check("rstmid_read_req", 32'(read_req), 32'd0);
      check("rstmid_err_cleared", 32'(ERR), 32'd0);
      check("rstmid_rdata", DATA_RDATA, 32'h0);
      check("rstmid_addr_out", addr_out, 32'h0);
      DATA_ENABLE = 1'b0;
      idle(2);
      RST = 1'b0; exp_rd = 32'h0;
      cfg_rd_data = 32'hBAD0BAD0; cfg_force_valid = 1'b1;
      idle(2);
      cfg_force_valid = 1'b0;
      idle(1);
      check("late_valid_rdata", DATA_RDATA, 32'h0);
      check("late_valid_read_req", 32'(read_req), 32'd0);
      check("late_valid_stall", 32'(DATA_STALL), 32'd0);
      cfg_rd_lat = 1; cfg_rd_data = 32'h0BADF00D; exp_rd = 32'h0BADF00D;
      access(1'b0, 32'h404, 32'h0, exp_rd, 3, 1'b0, "rd_after_rst");
      idle(2);

      // Back-to-back write then read, write_ready delayed 3 cycles
      cfg_wr_wait = 3; w0 = wr_req_cycles;
      access(1'b1, 32'h500, 32'h5A5A0001, exp_rd, POSTED ? 0 : 5, 1'b0, "b2b_wr");
      cfg_rd_data = 32'h600DCAFE; exp_rd = 32'h600DCAFE;
      access(1'b0, 32'h504, 32'h0, exp_rd, POSTED ? 7 : 3, 1'b0, "b2b_rd");
      idle(2);
      check("b2b_wr_req_cycles", 32'(wr_req_cycles - w0), 32'd4);
      check("b2b_wr_addr", mon_w_addr, 32'h500);
      check("b2b_wr_data", mon_w_data, 32'h5A5A0001);
      check("b2b_rd_addr", mon_r_addr, 32'h504);
      cfg_wr_wait = 0;

      // Watchdog on a write that is never accepted
      cfg_wr_hang = 1'b1; w0 = wr_req_cycles;
      access(1'b1, 32'h600, 32'h12121212, exp_rd, POSTED ? 0 : TIMEOUT + 1,
             POSTED ? 1'b0 : 1'b1, "wr_timeout");
      idle(TIMEOUT + 2);
      check("wr_timeout_req_cycles", 32'(wr_req_cycles - w0), 32'(TIMEOUT));
      check("wr_timeout_err", 32'(ERR), 32'd1);
      check("wr_timeout_rdata_kept", DATA_RDATA, exp_rd);
      cfg_wr_hang = 1'b0;

      check("req_overlap", 32'(overlap), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_ram_bridge.md
# dmem_ram_bridge

Core-side requester for the external RAM controller (`ram`). It converts the RISC-V core's level-style data-memory bus (`DATA_ENABLE`/`DATA_WRITE`/`DATA_ADDR`/`DATA_BUS`) into the controller's request/ready/valid handshake and stalls the core until each access completes. It is the initiator whose responder is the DDR3 RAM controller, and it sits between the core's MEM stage and `ram`. It includes a watchdog that completes hung accesses with an error flag.

## Interface
Parameters:
- `ADDR_W`, 32: address width, core and RAM sides.
- `DATA_W`, 32: data width.
- `TIMEOUT_CYCLES`, 1024: cycles an access may remain outstanding before the watchdog fires. Minimum 2.
- `ERR_DATA`, 32'hDEADBEEF: value returned on `DATA_RDATA` for a timed-out read.

Ports:
- `CLK` in 1: single clock for the whole block.
- `RST` in 1: asynchronous, active-high reset.
- `DATA_ENABLE` in 1: core requests an access.
- `DATA_WRITE` in 1: 1 means write, 0 means read. Qualified by `DATA_ENABLE`.
- `DATA_ADDR` in ADDR_W: access address.
- `DATA_BUS` in DATA_W: write data.
- `DATA_RDATA` out DATA_W: read data. Valid in the cycle `DATA_STALL` drops for a read.
- `DATA_STALL` out 1: core must hold its request while this is high.
- `ERR` out 1: sticky watchdog-timeout flag.
- `addr_out` out ADDR_W: address to `ram`.
- `write_data_out` out DATA_W: write data to `ram`.
- `read_req` out 1: read request to `ram`.
- `write_req` out 1: write request to `ram`.
- `read_ready` in 1: `ram` can accept a read.
- `write_ready` in 1: `ram` can accept a write.
- `read_data_valid` in 1: `read_data_in` carries the response.
- `read_data_in` in DATA_W: read response data.

## Operation
States are `IDLE`, `WR_REQ`, `RD_REQ`, `RD_WAIT` and `DONE`.

- **IDLE**
  - When `DATA_ENABLE` is high: capture `DATA_ADDR`, `DATA_BUS` and `DATA_WRITE` into holding registers.
  - Then go to `WR_REQ` if the access is a write, otherwise `RD_REQ`.
- **WR_REQ**
  - `write_req` is high.
  - A write is accepted on a clock edge where `write_req` and `write_ready` are both high; the block then goes to `DONE`.
- **RD_REQ**
  - `read_req` is high.
  - A read is accepted on an edge where `read_req` and `read_ready` are both high; the block then goes to `RD_WAIT`.
  - If `read_data_valid` is also high on that same edge, capture the data and go directly to `DONE`.
- **RD_WAIT**
  - On the first edge with `read_data_valid` high, capture `read_data_in` into `DATA_RDATA` and go to `DONE`.
- **DONE**
  - One cycle, then return to `IDLE`.

Output and protocol rules:
- `DATA_STALL` is combinational: `DATA_ENABLE && state != DONE`.
  - The core advances on the `DONE` edge.
  - The next cycle in `IDLE` starts the next access. Back-to-back accesses therefore have no idle bubble beyond `DONE`.
- `addr_out` and `write_data_out` are driven from the holding registers. They stay stable while a request is outstanding.
- `read_req` and `write_req` are never high together. Once raised, a request stays high until it is accepted or the watchdog fires.
- `read_data_valid` is ignored outside `RD_REQ` and `RD_WAIT`.
- `DATA_RDATA` holds its last value until the next read completes.
- Watchdog:
  - The counter clears on leaving `IDLE` and increments each cycle in `WR_REQ`, `RD_REQ` or `RD_WAIT`.
  - When it reaches `TIMEOUT_CYCLES - 1`: drop the request, load `ERR_DATA` into `DATA_RDATA` if the access is a read, set `ERR`, and go to `DONE`.
- `ERR` is cleared only by `RST`.

## Timing
- Reset values: `read_req`=0, `write_req`=0, `ERR`=0, `DATA_RDATA`=0, `addr_out`=0, `write_data_out`=0, state=`IDLE`.
  - `DATA_STALL` then equals `DATA_ENABLE`.
- Reset asserted mid-access: requests drop asynchronously and the in-flight access is abandoned. The block does not replay it.
- Minimum write latency, with `write_ready` already high: `DATA_ENABLE` is seen at edge 0, `write_req` is high in cycle 1 and accepted at edge 1, `DONE` is cycle 2, stall drops in cycle 2.
  - Total: 2 stalled cycles.
- Minimum read latency: with `read_ready` high and `read_data_valid` arriving one cycle after acceptance, there are 3 stalled cycles.

## Configuration
- `DMEM_POSTED_WRITE_EN` defined:
  - A write seen in `IDLE` is captured, and `DATA_STALL` is low in that same cycle, so the core advances immediately.
  - The block goes to `WR_REQ`. On acceptance it returns directly to `IDLE` with no `DONE` cycle.
  - Any access arriving while the block is not in `IDLE` stalls until it returns to `IDLE`.
  - A watchdog timeout on a posted write sets `ERR` and returns to `IDLE`.
- `DMEM_POSTED_WRITE_EN` undefined: writes behave as described in Operation and stall until accepted.

## Test plan
- Write to addr 0x100 with data 0xA5A5A5A5, `write_ready` held high -> `write_req` high for 1 cycle with `addr_out`=0x100 and `write_data_out`=0xA5A5A5A5; `DATA_STALL` high for 2 cycles.
- Read from 0x100, `read_ready` low for 5 cycles, then valid 2 cycles after acceptance with 0x12345678 -> `read_req` high for 6 cycles; `DATA_RDATA`=0x12345678 in the cycle stall drops; `read_req`/`write_req` never overlap.
- Read with `TIMEOUT_CYCLES`=8 and `ram` never ready -> `read_req` drops after 8 cycles; `DATA_RDATA`=0xDEADBEEF; `ERR`=1 and stays 1 on later successful accesses.
- `RST` pulsed during `RD_WAIT` -> `read_req` low immediately; state is `IDLE`; a late `read_data_valid` is ignored; the next read completes normally.
- With `DMEM_POSTED_WRITE_EN`: write then read issued back-to-back, `write_ready` delayed 3 cycles -> no stall on the write; the read stalls until the write is accepted, then completes with correct data.
